// File: rtl/trs_sync_controller_if.sv
// Word stream and decoded timing flags shared between the BT.656 source and the sync controller.
interface trs_sync_controller_if #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 12
);
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_active;
  logic                  sav_pulse;
  logic                  eav_pulse;
  logic                  field;
  logic                  vblank;
  logic [CNT_WIDTH-1:0]  line_word_cnt;
  logic                  trs_err;

  modport master (
    output din,
    input  dout, dout_active, sav_pulse, eav_pulse, field, vblank, line_word_cnt, trs_err
  );

  modport slave (
    input  din,
    output dout, dout_active, sav_pulse, eav_pulse, field, vblank, line_word_cnt, trs_err
  );
endinterface

// File: rtl/trs_sync_controller.sv
// BT.656 TRS detector and 4-clock delay line; all control flags line up with the delayed word on dout.
module trs_sync_controller #(
  parameter int DATA_WIDTH = 10,
  parameter int MAX_WORDS  = 1440,
  parameter int CNT_WIDTH  = 12
) (
  input logic                clk,
  input logic                reset_n,
  trs_sync_controller_if.slave bus
);
  typedef enum logic [1:0] {IDLE, P1, P2, P3} det_t;

  localparam logic [DATA_WIDTH-1:0] W_3FF    = '1;
  localparam logic [DATA_WIDTH-1:0] W_000    = '0;
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(MAX_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = CNT_WIDTH'(MAX_WORDS);

  det_t                             state;
  logic [3:0][DATA_WIDTH-1:0]       dly;
  logic [2:0]                       cd;
  logic                             active;
  logic [CNT_WIDTH-1:0]             cnt;
  logic                             sav_q, eav_q, err_q, field_q, vblank_q;
  logic                             f_bit, v_bit, h_bit, xyz_ok;

  assign f_bit  = bus.din[8];
  assign v_bit  = bus.din[7];
  assign h_bit  = bus.din[6];
  assign xyz_ok = bus.din[9]
                & (bus.din[5] == (v_bit ^ h_bit))
                & (bus.din[4] == (f_bit ^ h_bit))
                & (bus.din[3] == (f_bit ^ v_bit))
                & (bus.din[2] == (f_bit ^ v_bit ^ h_bit));

  // dly[3] holds the word sampled three edges ago, which is the XYZ's 3FF on the decode edge.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) dly <= '0;
    else          dly <= {dly[2:0], bus.din};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cd       <= '0;
      active   <= 1'b0;
      cnt      <= '0;
      sav_q    <= 1'b0;
      eav_q    <= 1'b0;
      err_q    <= 1'b0;
      field_q  <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      sav_q <= 1'b0;
      eav_q <= 1'b0;
      err_q <= 1'b0;

      if (active) begin
        if (cnt == CNT_LAST) begin
          active <= 1'b0;
          cnt    <= CNT_MAX;
          err_q  <= 1'b1;
        end else begin
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end

      if (cd != 3'd0) begin
        cd <= cd - 3'd1;
        if (cd == 3'd1) active <= 1'b1;
      end

      // TRS decode is last so it overrides the countdown and overrun updates above.
      case (state)
        IDLE: if (bus.din == W_3FF) state <= P1;
        P1: begin
          if (bus.din == W_000)      state <= P2;
          else if (bus.din != W_3FF) state <= IDLE;
        end
        P2: begin
          if (bus.din == W_000)      state <= P3;
          else if (bus.din == W_3FF) state <= P1;
          else                       state <= IDLE;
        end
        P3: begin
          state <= (bus.din == W_3FF) ? P1 : IDLE;
          if (!xyz_ok) begin
            err_q <= 1'b1;
          end else begin
            field_q  <= f_bit;
            vblank_q <= v_bit;
            if (h_bit) begin
              eav_q  <= 1'b1;
              err_q  <= 1'b0;
              active <= 1'b0;
              cd     <= '0;
            end else begin
              sav_q <= 1'b1;
              if (!v_bit) begin
                cd     <= 3'd4;
                cnt    <= '0;
                active <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dout          = dly[3];
  assign bus.dout_active   = active;
  assign bus.sav_pulse     = sav_q;
  assign bus.eav_pulse     = eav_q;
  assign bus.field         = field_q;
  assign bus.vblank        = vblank_q;
  assign bus.line_word_cnt = cnt;
  assign bus.trs_err       = err_q;
endmodule

// File: doc/trs_sync_controller.md
Name: trs_sync_controller

Overview:
- Sequences the fixed 4-clock delay path of the BT.656 parsing front end.
- Watches the raw 10-bit word stream for timing reference signals (3FF 000 000 XYZ) and decodes and validates the XYZ word.
- Emits SAV/EAV strobes, field and vblank state, and an active-video qualifier, all aligned to the 4-clock-delayed output stream, so downstream scramblers see data and control on the same cycle.

Parameters:
- DATA_WIDTH, 10, word width; only 10 is supported.
- MAX_WORDS, 1440, maximum active words per line (720 px, 4:2:2).
- CNT_WIDTH, 12, width of line_word_cnt; must satisfy 2^CNT_WIDTH > MAX_WORDS.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- din  in  DATA_WIDTH  raw BT.656 word, one per clock.
- dout  out  DATA_WIDTH  din delayed exactly 4 clocks.
- dout_active  out  1  dout is an active-video word.
- sav_pulse  out  1  one-cycle strobe while the SAV's 3FF is on dout.
- eav_pulse  out  1  one-cycle strobe while the EAV's 3FF is on dout.
- field  out  1  F bit of the last valid TRS.
- vblank  out  1  V bit of the last valid TRS.
- line_word_cnt  out  CNT_WIDTH  index of the current active word on dout.
- trs_err  out  1  one-cycle strobe for a bad XYZ or line overrun.

Behaviour:
- Reset state:
  - All outputs are 0.
  - Delay stages are 0.
  - Detector FSM is in IDLE.
  - Activation countdown is cleared.
  - Async assert, synchronous-style release on the first clk edge after reset_n rises.
- Delay: four register stages; a din sampled at edge k appears on dout after edge k+3. No bypass, no stall.
- Detector FSM, evaluated on din each edge:
  - IDLE: on 3FF, go to P1; otherwise stay.
  - P1: on 000, go to P2; on 3FF, stay in P1; otherwise go to IDLE.
  - P2: on 000, go to P3; on 3FF, go to P1; otherwise go to IDLE.
  - P3: din is XYZ. Decode it, then go to P1 if XYZ==3FF, else IDLE.
- XYZ decode:
  - Bit fields: bit9 must be 1; F=bit8, V=bit7, H=bit6.
  - Protection: P3=V^H (bit5), P2=F^H (bit4), P1=F^V (bit3), P0=F^V^H (bit2). bits1:0 are ignored.
  - Any mismatch: trs_err=1 for one cycle. No strobe, and field/vblank/active are unchanged.
- Alignment:
  - XYZ is sampled at edge k, so its 3FF sits on dout after edge k.
  - sav_pulse (H=0) or eav_pulse (H=1) is registered at edge k and is high in that same cycle.
  - field and vblank update at edge k.
- Active qualifier:
  - On a valid SAV with V=0, load countdown=4.
  - dout_active rises when the countdown expires, i.e. on the first word after XYZ on dout, which is 4 cycles after sav_pulse.
  - dout_active falls at the edge that raises eav_pulse; the EAV 3FF is never active.
  - An SAV with V=1 never sets active.
- line_word_cnt:
  - Reset to 0 when the countdown loads.
  - Increments after each active word.
  - Holds while inactive.
- Overrun: if MAX_WORDS active words pass without an EAV, dout_active drops, trs_err pulses once, and the counter holds at MAX_WORDS until the next SAV.
- Simultaneous or overlapping events:
  - An EAV during a pending countdown cancels it; active never asserts.
  - A second SAV while active restarts the countdown and deasserts dout_active until it expires.
  - An error XYZ while active leaves active unchanged.
- Reset mid-line: every flag and the counter clear immediately; the delay line flushes to 0.

Test Plan:
- Delay: din=0..11 on successive clocks, no TRS → dout equals din from 4 clocks earlier; all flags stay 0.
- SAV: send 3FF,000,000,200, then words 040,200,... → sav_pulse high exactly when dout==3FF. dout_active rises on the dout word following 200 on dout. line_word_cnt=0 on the first active word.
- EAV: after 8 active words send 3FF,000,000,274 → dout_active falls and eav_pulse rises in the same cycle, while dout==3FF. line_word_cnt stays at 8. field=0, vblank=0.
- Vblank SAV: send XYZ=2AC → sav_pulse, vblank=1, dout_active never asserts. Then send field-1 EAV 3FF,000,000,3C4 → field=1.
- Error: send XYZ=210 → trs_err for one cycle, no sav_pulse or eav_pulse, flags unchanged. Sequence 3FF,3FF,000,000,200 still yields a valid SAV.
- Overrun/reset: with MAX_WORDS=4, send SAV then 6 data words → active for exactly 4 words, trs_err once, counter holds at 4. Pulsing reset_n low mid-line → all outputs 0 asynchronously.
